// File: rtl/alu_arbiter.sv
// Purpose: round-robin arbiter sharing one external combinational ALU between two requesters.
// Latency: handshake in cycle N, ALU driven in N+1, response pulse in N+2; next accept no earlier than N+3.
// Backpressure: reqN_ready is high only in IDLE, and only for the granted requester; the other requester waits.
//
// Ports:
//   clk, reset                     - single clock, synchronous active-high reset
//   reqN_valid/ready/code/a/b      - requester N operation handshake and operands (N = 0, 1)
//   rspN_valid                     - one-cycle response pulse for requester N
//   rsp_result/rsp_zero/rsp_err    - response payload; holds its last value outside the pulse
//   alu_code/alu_a/alu_b           - drive the shared ALU (forced to zero except while executing)
//   alu_result/alu_zero            - combinational return from the shared ALU
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_code,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_code,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,

  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,

  output logic [3:0]        alu_code,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  localparam logic [3:0] CODE_AND = 4'b0000;
  localparam logic [3:0] CODE_OR  = 4'b0001;
  localparam logic [3:0] CODE_ADD = 4'b0010;
  localparam logic [3:0] CODE_SUB = 4'b0110;
  localparam logic [3:0] CODE_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Requester that was accepted most recently; loses the next tie.
  logic                r_last_grant;

  // Operation captured at handshake, replayed to the ALU in EXEC.
  logic [3:0]          r_code;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_id;
  logic                r_illegal;

  // Response payload registers; only written at the end of EXEC.
  logic [DATA_W-1:0]   r_rsp_result;
  logic                r_rsp_zero;
  logic                r_rsp_err;

  logic                w_any_valid;
  logic                w_grant_id;
  logic                w_hs;
  logic [3:0]          w_sel_code;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic                w_sel_legal;

  function automatic logic code_is_legal(input logic [3:0] code);
    logic legal;
    legal = 1'b0;
    case (code)
      CODE_AND, CODE_OR, CODE_ADD, CODE_SUB, CODE_SLT: legal = 1'b1;
      default:                                         legal = 1'b0;
    endcase
    return legal;
  endfunction

  // ---------------------------------------------------------------------------
  // Round-robin grant. A lone valid wins outright; on a tie the requester that
  // was not served last wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      w_grant_id = ~r_last_grant;
    end else begin
      w_grant_id = req1_valid;
    end
  end

  // Operand mux for the capture registers, selected by the grant.
  always_comb begin
    w_sel_code  = w_grant_id ? req1_code : req0_code;
    w_sel_a     = w_grant_id ? req1_a    : req0_a;
    w_sel_b     = w_grant_id ? req1_b    : req0_b;
    w_sel_legal = code_is_legal(w_sel_code);
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and outputs.
  // Ready and response pulses are additionally gated by reset so nothing is
  // accepted or reported in a cycle whose edge is going to clear the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    alu_code    = 4'b0000;
    alu_a       = '0;
    alu_b       = '0;

    case (r_state)
      ST_IDLE: begin
        if (!reset && w_any_valid) begin
          // The granted requester's valid is high by construction of the grant.
          req0_ready  = ~w_grant_id;
          req1_ready  = w_grant_id;
          w_hs        = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // Illegal codes never reach the ALU; its inputs stay at zero.
        if (!r_illegal) begin
          alu_code = r_code;
          alu_a    = r_a;
          alu_b    = r_b;
        end
        w_state_nxt = ST_DONE;
      end

      ST_DONE: begin
        if (!reset) begin
          rsp0_valid = ~r_id;
          rsp1_valid = r_id;
        end
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, capture and response registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_code       <= 4'b0000;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_illegal    <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_hs) begin
        r_code       <= w_sel_code;
        r_a          <= w_sel_a;
        r_b          <= w_sel_b;
        r_id         <= w_grant_id;
        r_illegal    <= ~w_sel_legal;
        r_last_grant <= w_grant_id;
      end

      // ALU output is sampled at the end of EXEC so it is stable for DONE and
      // then held until the next operation completes.
      if (r_state == ST_EXEC) begin
        if (r_illegal) begin
          r_rsp_result <= '0;
          r_rsp_zero   <= 1'b0;
          r_rsp_err    <= 1'b1;
        end else begin
          r_rsp_result <= alu_result;
          r_rsp_zero   <= alu_zero;
          r_rsp_err    <= 1'b0;
        end
      end
    end
  end

  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_err    = r_rsp_err;

endmodule
